// File: rtl/dm_responder.sv
// dm_responder
// -----------------------------------------------------------------------------
// Data-memory responder that sits on the memory side of the CPU data port.
// It holds a word-organised RAM behind a req/ack handshake. A programmable
// wait-state counter gives the multi-cycle CPU a realistic, non-zero latency.
// Misaligned and out-of-range accesses are reported with dm_err. They are not
// aliased onto a valid word.
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two, 4..65536)
//   WAIT_CYCLES  extra cycles between accept and ack (0..15)
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          asynchronous, active-low reset
//   dm_req       request valid from the CPU
//   dm_ready     responder can accept a request (high only while idle)
//   dm_write     1 = store, 0 = load; sampled on accept
//   dm_addr      byte address; sampled on accept
//   dm_data_in   store data; sampled on accept
//   dm_strb      byte strobes for stores (only when DM_STRB_EN is defined)
//   dm_data_out  load data / store echo; valid with dm_ack, held until next ack
//   dm_ack       one-cycle completion pulse
//   dm_err       error qualifier, meaningful only while dm_ack is high
//
// Optional feature macro: DM_STRB_EN (adds byte-strobed stores).
// -----------------------------------------------------------------------------
module dm_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dm_req,
    output logic        dm_ready,
    input  logic        dm_write,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_data_in,
`ifdef DM_STRB_EN
    input  logic [3:0]  dm_strb,
`endif
    output logic [31:0] dm_data_out,
    output logic        dm_ack,
    output logic        dm_err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic [3:0]    counter;

    logic          lat_write;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_data;
`ifdef DM_STRB_EN
    logic [3:0]    lat_strb;
    logic [3:0]    acc_strb;
`endif

    logic [31:0]   ram [DEPTH];

    logic          accept;
    logic          do_access;
    logic          acc_write;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_data;
    logic          acc_err;
    logic [AW-1:0] acc_index;
    logic [31:0]   merged;

    assign dm_ready = (state == S_IDLE);
    assign dm_ack   = (state == S_DONE);
    assign accept   = dm_req && dm_ready;

    // Next-state logic. While BUSY, dm_req is ignored. Nothing is queued.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = (WAIT_CYCLES == 0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (counter == 4'd1) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // The RAM access happens on the edge that enters DONE.
    assign do_access = (next_state == S_DONE);

    // When WAIT_CYCLES is 0, the access edge is also the accept edge. In that
    // case the live request inputs are used, because nothing is latched yet.
    always_comb begin
        acc_write = lat_write;
        acc_addr  = lat_addr;
        acc_data  = lat_data;
`ifdef DM_STRB_EN
        acc_strb  = lat_strb;
`endif
        if (state == S_IDLE) begin
            acc_write = dm_write;
            acc_addr  = dm_addr;
            acc_data  = dm_data_in;
`ifdef DM_STRB_EN
            acc_strb  = dm_strb;
`endif
        end
    end

    // An access is in error if it is misaligned, or if any address bit above
    // the word index is set (that is, byte address >= DEPTH*4).
    assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);
    assign acc_index = acc_addr[AW+1:2];

    // Build the word that a store writes and echoes. With strobes enabled,
    // each unselected byte keeps its current RAM contents.
    always_comb begin
        merged = acc_data;
`ifdef DM_STRB_EN
        for (int i = 0; i < 4; i++) begin
            if (!acc_strb[i]) begin
                merged[8*i +: 8] = ram[acc_index][8*i +: 8];
            end
        end
`endif
    end

    // Control state, request latches and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            counter     <= 4'd0;
            lat_write   <= 1'b0;
            lat_addr    <= 32'd0;
            lat_data    <= 32'd0;
`ifdef DM_STRB_EN
            lat_strb    <= 4'd0;
`endif
            dm_data_out <= 32'd0;
            dm_err      <= 1'b0;
        end else begin
            state <= next_state;

            if (accept) begin
                lat_write <= dm_write;
                lat_addr  <= dm_addr;
                lat_data  <= dm_data_in;
`ifdef DM_STRB_EN
                lat_strb  <= dm_strb;
`endif
                counter   <= WAIT_LOAD;
            end else if (state == S_BUSY) begin
                counter <= counter - 4'd1;
            end

            if (do_access) begin
                dm_err <= acc_err;
                if (acc_err) begin
                    dm_data_out <= 32'd0;
                end else if (acc_write) begin
                    dm_data_out <= merged;
                end else begin
                    dm_data_out <= ram[acc_index];
                end
            end else if (state == S_DONE) begin
                dm_err <= 1'b0;
            end
        end
    end

    // RAM storage has no reset. The write is gated by rst so that a reset
    // which lands on an access edge never commits a store.
    always_ff @(posedge clk) begin
        if (do_access && rst && acc_write && !acc_err) begin
            ram[acc_index] <= merged;
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder
// -----------------------------------------------------------------------------
// Scoreboard bench for dm_responder (DEPTH=1024, WAIT_CYCLES=2).
// The stimulus tasks push the expected response into a queue. The expected
// values are hand-computed, and each entry includes the cycle in which the
// ack must appear. A separate monitor pops one entry for every dm_ack it sees
// on a falling edge and compares the entry with the response.
// The strobe scenario is built only when DM_STRB_EN is defined.
// -----------------------------------------------------------------------------
module tb_dm_responder;

    localparam int DEPTH = 1024;
    localparam int W     = 2;

    logic        clk;
    logic        rst;
    logic        dm_req;
    logic        dm_ready;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_data_in;
    logic [31:0] dm_data_out;
    logic        dm_ack;
    logic        dm_err;
`ifdef DM_STRB_EN
    logic [3:0]  dm_strb;
`endif

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    dm_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dm_req      (dm_req),
        .dm_ready    (dm_ready),
        .dm_write    (dm_write),
        .dm_addr     (dm_addr),
        .dm_data_in  (dm_data_in),
`ifdef DM_STRB_EN
        .dm_strb     (dm_strb),
`endif
        .dm_data_out (dm_data_out),
        .dm_ack      (dm_ack),
        .dm_err      (dm_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so that ack timing can be checked in absolute cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (dm_ack) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_ack: actual=ack at cycle %0d required=no ack", cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput({mon_e.name, "_data"}, dm_data_out, mon_e.data);
                checkOutput({mon_e.name, "_err"}, {31'd0, dm_err}, {31'd0, mon_e.err});
                checkOutput({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    // Present one request and wait (bounded) until it is accepted.
    // The accept edge is the rising edge that follows the falling edge on
    // which dm_ready is seen high. The ack then appears W cycles later.
    task automatic applyStimulus(input string name, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [31:0] exp_data,
                                 input logic exp_err, input bit push);
        int waited = 0;
        exp_t e;
        @(negedge clk);
        dm_write   = wr;
        dm_addr    = addr;
        dm_data_in = data;
        dm_req     = 1'b1;
        while (!dm_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!dm_ready) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s_accept: actual=ready low for 20 cycles required=ready high", name);
            dm_req = 1'b0;
            return;
        end
        if (push) begin
            e.name = name;
            e.data = exp_data;
            e.err  = exp_err;
            e.cyc  = cyc + 1 + W;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 dm_req = 1'b0;
    endtask

    initial begin
        int waited;
        int k;
        exp_t e;

        rst        = 1'b1;
        dm_req     = 1'b0;
        dm_write   = 1'b0;
        dm_addr    = 32'd0;
        dm_data_in = 32'd0;
`ifdef DM_STRB_EN
        dm_strb    = 4'hF;
`endif
        #2 rst = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_ready", {31'd0, dm_ready}, 32'd1);
        checkOutput("reset_ack", {31'd0, dm_ack}, 32'd0);
        checkOutput("reset_err", {31'd0, dm_err}, 32'd0);
        checkOutput("reset_data", dm_data_out, 32'd0);
        rst = 1'b1;
        #1 checkOutput("release_ready", {31'd0, dm_ready}, 32'd1);

        // Store, then load back; dm_ready is low for W+1 cycles after accept
        applyStimulus("store10", 1'b1, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1);
        applyStimulus("load10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        for (int i = 0; i < W + 1; i++) begin
            @(negedge clk);
            checkOutput("busy_ready", {31'd0, dm_ready}, 32'd0);
        end
        @(negedge clk);
        checkOutput("idle_ready", {31'd0, dm_ready}, 32'd1);

        // Misaligned store must not write
        applyStimulus("mis_store", 1'b1, 32'h12, 32'h1, 32'h0, 1'b1, 1'b1);
        applyStimulus("load10_after_mis", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);

        // Address range boundary
        applyStimulus("load_oor", 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1'b1);
        applyStimulus("store_ffc", 1'b1, 32'hFFC, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b1);
        applyStimulus("load_ffc", 1'b0, 32'hFFC, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);

        // dm_req held high: the second accept comes only after returning to IDLE
        waited = 0;
        @(negedge clk);
        dm_write = 1'b0;
        dm_addr  = 32'h10;
        dm_req   = 1'b1;
        while (!dm_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        k = cyc;
        e.data = 32'hDEADBEEF;
        e.err  = 1'b0;
        e.name = "held_first";
        e.cyc  = k + 1 + W;
        sb.push_back(e);
        e.name = "held_second";
        e.cyc  = k + 2 * W + 3;
        sb.push_back(e);
        repeat (W + 3) @(posedge clk);
        #1 dm_req = 1'b0;

        // Reset during BUSY aborts the store
        applyStimulus("store20", 1'b1, 32'h20, 32'h12345678, 32'h12345678, 1'b0, 1'b1);
        applyStimulus("abort20", 1'b1, 32'h20, 32'h55AA55AA, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("abort_ack", {31'd0, dm_ack}, 32'd0);
        rst = 1'b1;
        #1 checkOutput("abort_release_ready", {31'd0, dm_ready}, 32'd1);
        applyStimulus("load20", 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 1'b1);

`ifdef DM_STRB_EN
        // Byte-strobed stores
        dm_strb = 4'b1111;
        applyStimulus("strb_full", 1'b1, 32'h30, 32'h11223344, 32'h11223344, 1'b0, 1'b1);
        dm_strb = 4'b0101;
        applyStimulus("strb_0101", 1'b1, 32'h30, 32'hAABBCCDD, 32'h11BB33DD, 1'b0, 1'b1);
        dm_strb = 4'b0000;
        applyStimulus("strb_none", 1'b1, 32'h30, 32'hFFFFFFFF, 32'h11BB33DD, 1'b0, 1'b1);
        dm_strb = 4'b0000;
        applyStimulus("strb_load", 1'b0, 32'h30, 32'h0, 32'h11BB33DD, 1'b0, 1'b1);
        dm_strb = 4'b1111;
`endif

        // Wait (bounded) for all outstanding acks, then allow some idle time
        // so that any extra ack is detected.
        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain: actual=%0d acks outstanding required=0", sb.size());
        end
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
